muldiv_hilo: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_hilo.sv | 139 +++++++++++++
 tb/tb_muldiv_hilo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its HI/LO register pair.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring-divide step.
// acc holds {upper product, multiplier} when multiplying, {remainder, dividend/quotient} when dividing.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    // Partial remainder (WIDTH+1 bits) with the next dividend bit shifted in.
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    fits     = (shifted >= {1'b0, b});
    // When the trial subtract succeeds the true difference is below b, so WIDTH bits suffice.
    diff     = shifted[WIDTH-1:0] - b;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (fits) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair; one bit per cycle, then a sign-fix cycle.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               is_div_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;

  logic               x_neg;
  logic               y_neg;
  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    x_neg = md_is_signed(op) & x[WIDTH-1];
    y_neg = md_is_signed(op) & y[WIDTH-1];
    x_mag = x_neg ? -x : x;
    y_mag = y_neg ? -y : y;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode(is_div_reg),
    .acc     (acc_reg),
    .b       (b_reg),
    .acc_next(acc_next)
  );

  // Sign fix applied in FIX; the divide flags already exclude the divide-by-zero quotient.
  always_comb begin
    prod    = neg_lo_reg ? -acc_reg : acc_reg;
    lo_next = prod[WIDTH-1:0];
    hi_next = prod[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      lo_next = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      hi_next = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state_reg  <= CALC;
                busy_reg   <= 1'b1;
                cnt_reg    <= '0;
                is_div_reg <= md_is_div(op);
                if (md_is_div(op)) begin
                  acc_reg    <= {{WIDTH{1'b0}}, x_mag};
                  b_reg      <= y_mag;
                  neg_lo_reg <= (x_neg ^ y_neg) && (y != '0);
                  neg_hi_reg <= x_neg;
                end else begin
                  acc_reg    <= {{WIDTH{1'b0}}, y_mag};
                  b_reg      <= x_mag;
                  neg_lo_reg <= x_neg ^ y_neg;
                  neg_hi_reg <= 1'b0;
                end
              end
              MD_MTHI: hi_reg <= x;
              MD_MTLO: lo_reg <= x;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: vector table, reference model, scoreboard on done.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .x    (x),
    .y    (y),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_cnt = 0;
  int   done_exp = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, req);
  endtask

  task automatic add_vec(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.name = nm; v.op = o; v.x = a; v.y = b; v.hi = eh; v.lo = el;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    e.name = nm; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    done_exp++;
  endtask

  // Reference: plain 64-bit arithmetic, with the divide-by-zero convention spelled out.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (o)
      MD_MULT:  res = 64'(sa * sb);
      MD_MULTU: res = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == '0) res = {a, {W{1'b1}}};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[W-1:0], q[W-1:0]};
        end
      end
      MD_DIVU: begin
        if (b == '0) res = {a, {W{1'b1}}};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Caller sits at a negedge; returns at the negedge of the done cycle.
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s_timeout: got no done within 40 cycles, want done", nm);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    start = 1'b1; op = o; x = a; y = b;
    push_exp(nm, eh, el);
    $display("op %s: op=%0d x=%h y=%h expect hi=%h lo=%h", nm, o, a, b, eh, el);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 3)); x = $urandom; y = $urandom;
    wait_done(nm);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done=1 with no op pending, want done=0");
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*W-1:0] m;
    logic [2:0]     ro;
    logic [W-1:0]   ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    rst = 1'b0;
    @(negedge clk);

    // Latency profile: start sampled at E0, busy cycles 1..33, done only in cycle 34.
    start = 1'b1; op = MD_MULTU; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF;
    push_exp("multu_max", 32'hFFFFFFFE, 32'h00000001);
    $display("op multu_max: latency profile");
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; x = '0; y = '0; end
      check($sformatf("busy_c%0d", c), 32'(busy), (c <= 33) ? 32'd1 : 32'd0);
      check($sformatf("done_c%0d", c), 32'(done), (c == 34) ? 32'd1 : 32'd0);
    end

    add_vec("mult_m3x7",     MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    add_vec("div_m7d2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec("divu_100d7",    MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    add_vec("div_ovf",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add_vec("divu_by0",      MD_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    add_vec("div_m5_by0",    MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    add_vec("mult_min2",     MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add_vec("mult_7xm1",     MD_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9);
    add_vec("div_7dm2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    add_vec("multu_2p16sq",  MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);

    // Each op is started in the previous op's done cycle.
    foreach (vecs[i]) issue(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? '0 : ((i == 4) ? 32'($urandom_range(1, 9)) : $urandom);
      m  = model(ro, ra, rb);
      issue($sformatf("rand%0d", i), ro, ra, rb, m[2*W-1:W], m[W-1:0]);
    end

    // A start during CALC must be neither queued nor captured.
    start = 1'b1; op = MD_MULTU; x = 32'd3; y = 32'd5;
    push_exp("busy_ignore", 32'd0, 32'd15);
    $display("op busy_ignore: MULTU 3x5 with DIVU start mid-calc");
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MD_DIVU; x = 32'd100; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore_busy", 32'(busy), 32'd1);
    wait_done("busy_ignore");
    repeat (40) @(negedge clk);

    $display("op mthi_mtlo: back-to-back moves");
    start = 1'b1; op = MD_MTHI; x = 32'hA5A5A5A5;
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mthi_busy", 32'(busy), 32'd0);
    op = MD_MTLO; x = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h5A5A5A5A);
    check("mtlo_hi_hold", hi, 32'hA5A5A5A5);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);

    // Abort a multiply with a one-cycle reset in cycle 10.
    $display("op rst_abort: MULTU aborted by reset");
    start = 1'b1; op = MD_MULTU; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    issue("divu_after_rst", MD_DIVU, 32'd1000, 32'd9, 32'd1, 32'd111);

    repeat (40) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'(done_exp));
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
